// File: rtl/vga_pkg.sv
// Shared VGA mode constants and helpers for the timing generator and its axis counters.
// Default mode is 640x480@60; an 800x600@72 set is provided for other boards.
package vga_pkg;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;
  localparam int VGA640_H_TOTAL  = axis_total(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP);
  localparam int VGA640_V_TOTAL  = axis_total(VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP);
  localparam int VGA640_HS_START = sync_start(VGA640_H_ACTIVE, VGA640_H_FP);
  localparam int VGA640_HS_END   = sync_end(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC);
  localparam int VGA640_VS_START = sync_start(VGA640_V_ACTIVE, VGA640_V_FP);
  localparam int VGA640_VS_END   = sync_end(VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC);

  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 56;
  localparam int VGA800_H_SYNC   = 120;
  localparam int VGA800_H_BP     = 64;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 37;
  localparam int VGA800_V_SYNC   = 6;
  localparam int VGA800_V_BP     = 23;
  localparam bit VGA800_HS_POL   = 1'b1;
  localparam bit VGA800_VS_POL   = 1'b1;
  localparam int VGA800_H_TOTAL  = axis_total(VGA800_H_ACTIVE, VGA800_H_FP, VGA800_H_SYNC, VGA800_H_BP);
  localparam int VGA800_V_TOTAL  = axis_total(VGA800_V_ACTIVE, VGA800_V_FP, VGA800_V_SYNC, VGA800_V_BP);
  localparam int VGA800_HS_START = sync_start(VGA800_H_ACTIVE, VGA800_H_FP);
  localparam int VGA800_HS_END   = sync_end(VGA800_H_ACTIVE, VGA800_H_FP, VGA800_H_SYNC);
  localparam int VGA800_VS_START = sync_start(VGA800_V_ACTIVE, VGA800_V_FP);
  localparam int VGA800_VS_END   = sync_end(VGA800_V_ACTIVE, VGA800_V_FP, VGA800_V_SYNC);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): wrapping position counter plus
// active-region and sync-window decode of the current position.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA640_H_ACTIVE,
  parameter int FP     = VGA640_H_FP,
  parameter int SYNC   = VGA640_H_SYNC,
  parameter int BP     = VGA640_H_BP,
  parameter bit POL    = 1'b0,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int            TOTAL  = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT    = CW'(ACTIVE);
  localparam logic [CW-1:0] SS     = CW'(sync_start(ACTIVE, FP));
  localparam logic [CW-1:0] SE     = CW'(sync_end(ACTIVE, FP, SYNC));

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // wrap is the carry into the next axis, so it only fires on a real advance.
  assign cnt    = cnt_q;
  assign wrap   = inc && !clr && (cnt_q == LAST);
  assign active = (cnt_q < ACT);
  assign sync   = ((cnt_q >= SS) && (cnt_q <= SE)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock divider, H/V counters, strobes,
// frame counter and registered, blanked colour/sync pins.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = VGA640_HS_POL,
  parameter bit VS_POL   = VGA640_VS_POL,
  parameter int PIX_DIV  = 1,
  parameter int CW       = 11,
  parameter int RW       = 3,
  parameter int GW       = 3,
  parameter int BW       = 2,
  parameter int FCW      = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [RW-1:0]  rin,
  input  logic [GW-1:0]  gin,
  input  logic [BW-1:0]  bin,
  output logic [CW-1:0]  hc,
  output logic [CW-1:0]  vc,
  output logic           pix_tick,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt,
  output logic [RW-1:0]  rout,
  output logic [GW-1:0]  gout,
  output logic [BW-1:0]  bout,
  output logic           hs,
  output logic           vs,
  output logic           de
);

  localparam int            DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0]  div_q, div_d;
  logic           tick, h_wrap, v_wrap, h_act, v_act, h_sync, v_sync, pix_active;
  logic           pix_tick_q, pix_tick_d, line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [RW-1:0]  r_q, r_d;
  logic [GW-1:0]  g_q, g_d;
  logic [BW-1:0]  b_q, b_d;

  // Handshake: pix_tick is a one-clk strobe with no back-pressure; hc/vc and
  // every pin register change only in clks where it is high and hold otherwise.
  assign tick       = en && (div_q == DIV_LAST);
  assign pix_active = h_act && v_act;

  always_comb begin
    div_d = div_q + DW'(1);
    if (!en || tick) begin
      div_d = '0;
    end
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
  ) u_h (
    .clk(clk), .rst(rst), .clr(!en), .inc(tick),
    .cnt(hc), .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
  ) u_v (
    .clk(clk), .rst(rst), .clr(!en), .inc(h_wrap),
    .cnt(vc), .wrap(v_wrap), .active(v_act), .sync(v_sync)
  );

  // Pin registers capture the pixel the renderer saw during the period the tick closes.
  always_comb begin
    pix_tick_d    = tick;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
    frame_cnt_d   = frame_cnt_q;
    de_d          = de_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    if (h_wrap && v_wrap) begin
      frame_cnt_d = frame_cnt_q + FCW'(1);
    end
    if (tick) begin
      de_d = pix_active;
      r_d  = pix_active ? rin : '0;
      g_d  = pix_active ? gin : '0;
      b_d  = pix_active ? bin : '0;
      hs_d = h_sync;
      vs_d = v_sync;
    end
    if (!en) begin
      frame_cnt_d = '0;
      de_d        = 1'b0;
      r_d         = '0;
      g_d         = '0;
      b_d         = '0;
      hs_d        = ~HS_POL;
      vs_d        = ~VS_POL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      de_q          <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
    end else begin
      div_q         <= div_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      de_q          <= de_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
  assign de          = de_q;
  assign rout        = r_q;
  assign gout        = g_q;
  assign bout        = b_q;
  assign hs          = hs_q;
  assign vs          = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance (PIX_DIV=1) and a tiny
// positive-sync mode (PIX_DIV=2) driven together and checked against a pixel-index model.
module tb_vga_timing_gen;

  localparam int W = 44;

  localparam int B_HA = 10, B_HFP = 2, B_HS = 3, B_HBP = 2;
  localparam int B_VA = 6,  B_VFP = 1, B_VS = 2, B_VBP = 2;
  localparam int B_DIV = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [2:0] rin = '0;
  logic [2:0] gin = '0;
  logic [1:0] bin = '0;

  always #5 clk = ~clk;

  logic [10:0] a_hc, a_vc, b_hc, b_vc;
  logic        a_pix_tick, a_line_start, a_frame_start, a_hs, a_vs, a_de;
  logic        b_pix_tick, b_line_start, b_frame_start, b_hs, b_vs, b_de;
  logic [7:0]  a_frame_cnt, b_frame_cnt;
  logic [2:0]  a_rout, a_gout, b_rout, b_gout;
  logic [1:0]  a_bout, b_bout;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .en(en), .rin(rin), .gin(gin), .bin(bin),
    .hc(a_hc), .vc(a_vc), .pix_tick(a_pix_tick), .line_start(a_line_start),
    .frame_start(a_frame_start), .frame_cnt(a_frame_cnt),
    .rout(a_rout), .gout(a_gout), .bout(a_bout), .hs(a_hs), .vs(a_vs), .de(a_de)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(B_DIV)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .rin(rin), .gin(gin), .bin(bin),
    .hc(b_hc), .vc(b_vc), .pix_tick(b_pix_tick), .line_start(b_line_start),
    .frame_start(b_frame_start), .frame_cnt(b_frame_cnt),
    .rout(b_rout), .gout(b_gout), .bout(b_bout), .hs(b_hs), .vs(b_vs), .de(b_de)
  );

  logic [W-1:0] act_a, act_b;
  assign act_a = {a_pix_tick, a_line_start, a_frame_start, a_hc, a_vc, a_frame_cnt,
                  a_rout, a_gout, a_bout, a_hs, a_vs, a_de};
  assign act_b = {b_pix_tick, b_line_start, b_frame_start, b_hs_dummy_fix(b_hc), b_vc, b_frame_cnt,
                  b_rout, b_gout, b_bout, b_hs, b_vs, b_de};

  function automatic logic [10:0] b_hs_dummy_fix(input logic [10:0] x);
    return x;
  endfunction

  // ---------------- reference model ----------------
  int     ha[2], hfp[2], hsw[2], ht[2], va[2], vfp[2], vsw[2], vt[2], div[2];
  bit     hpol[2], vpol[2];
  int     run_c[2];
  longint p_idx[2];
  logic [W-1:0] last_v[2];

  function automatic logic [W-1:0] idle_vec(input int d);
    logic [W-1:0] v;
    v    = '0;
    v[2] = ~hpol[d];
    v[1] = ~vpol[d];
    return v;
  endfunction

  // Output after the tick that closes pixel number p (counted from the (0,0) start).
  function automatic logic [W-1:0] pixel_vec(input int d, input longint p,
                                             input logic [2:0] r, input logic [2:0] g,
                                             input logic [1:0] b);
    logic [W-1:0] v;
    longint np, fr;
    int hp, vp;
    bit act;
    np  = p + 1;
    fr  = longint'(ht[d]) * vt[d];
    hp  = int'(p % ht[d]);
    vp  = int'((p / ht[d]) % vt[d]);
    act = (hp < ha[d]) && (vp < va[d]);
    v        = '0;
    v[43]    = 1'b1;
    v[42]    = (np % ht[d]) == 0;
    v[41]    = (np % fr) == 0;
    v[40:30] = 11'(np % ht[d]);
    v[29:19] = 11'((np / ht[d]) % vt[d]);
    v[18:11] = 8'((np / fr) % 256);
    v[10:8]  = act ? r : 3'b000;
    v[7:5]   = act ? g : 3'b000;
    v[4:3]   = act ? b : 2'b00;
    v[2]     = (hp >= ha[d] + hfp[d] && hp < ha[d] + hfp[d] + hsw[d]) ? hpol[d] : ~hpol[d];
    v[1]     = (vp >= va[d] + vfp[d] && vp < va[d] + vfp[d] + vsw[d]) ? vpol[d] : ~vpol[d];
    v[0]     = act;
    return v;
  endfunction

  function automatic logic [W-1:0] model_step(input int d, input bit en_v,
                                              input logic [2:0] r, input logic [2:0] g,
                                              input logic [1:0] b);
    logic [W-1:0] v;
    if (!en_v) begin
      run_c[d] = 0;
      p_idx[d] = 0;
      v        = idle_vec(d);
    end else begin
      run_c[d]++;
      if (run_c[d] % div[d] == 0) begin
        v = pixel_vec(d, p_idx[d], r, g, b);
        p_idx[d]++;
      end else begin
        v        = last_v[d];
        v[43:41] = 3'b000;
      end
    end
    last_v[d] = v;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_e;
  int errors = 0;
  int checks = 0;

  task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  bit cnt_en = 1'b0;
  int a_de_n, a_hs_low, a_ls, b_ticks, b_de_n, b_fs, b_vs_hi, b_leak;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      check_vec("dut_a outputs", act_a, exp_e[W-1:0]);
      check_vec("dut_b outputs", act_b, exp_e[2*W-1:W]);
    end
    if (cnt_en) begin
      if (a_pix_tick && a_de) a_de_n++;
      if (a_pix_tick && !a_hs) a_hs_low++;
      if (a_line_start) a_ls++;
      if (b_pix_tick) b_ticks++;
      if (b_pix_tick && b_de) b_de_n++;
      if (b_frame_start) b_fs++;
      if (b_pix_tick && b_vs) b_vs_hi++;
      if ((!b_de && b_rout != 3'b000) || (b_de && b_rout != 3'b101)) b_leak++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge; sets inputs for the coming posedge and returns at the next negedge.
  task automatic drive_cycle(input bit rst_v, input bit en_v, input logic [2:0] r,
                             input logic [2:0] g, input logic [1:0] b);
    logic [W-1:0] ea, eb;
    en  = en_v;
    rin = r;
    gin = g;
    bin = b;
    if (rst_v) begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
        run_c[d]  = 0;
        p_idx[d]  = 0;
        last_v[d] = idle_vec(d);
      end
      ea = idle_vec(0);
      eb = idle_vec(1);
    end else begin
      rst = 1'b0;
      ea  = model_step(0, en_v, r, g, b);
      eb  = model_step(1, en_v, r, g, b);
    end
    exp_q.push_back({eb, ea});
    @(negedge clk);
  endtask

  task automatic run_random(input int n, input bit en_v);
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b0, en_v, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)));
    end
  endtask

  task automatic async_reset(input string name);
    rst = 1'b1;
    #1;
    check_vec({name, " dut_a async"}, act_a, idle_vec(0));
    check_vec({name, " dut_b async"}, act_b, idle_vec(1));
    drive_cycle(1'b1, 1'b0, 3'b000, 3'b000, 2'b00);
  endtask

  task automatic clear_counts();
    a_de_n = 0; a_hs_low = 0; a_ls = 0;
    b_ticks = 0; b_de_n = 0; b_fs = 0; b_vs_hi = 0; b_leak = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ha[0] = 640;  hfp[0] = 16;    hsw[0] = 96;   va[0] = 480;  vfp[0] = 10;    vsw[0] = 2;
    ht[0] = 800;  vt[0]  = 525;   div[0] = 1;    hpol[0] = 1'b0; vpol[0] = 1'b0;
    ha[1] = B_HA; hfp[1] = B_HFP; hsw[1] = B_HS; va[1] = B_VA; vfp[1] = B_VFP; vsw[1] = B_VS;
    ht[1] = B_HA + B_HFP + B_HS + B_HBP;  vt[1] = B_VA + B_VFP + B_VS + B_VBP;
    div[1] = B_DIV; hpol[1] = 1'b1; vpol[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      run_c[d] = 0; p_idx[d] = 0; last_v[d] = idle_vec(d);
    end
    clear_counts();

    @(negedge clk);
    repeat (3) drive_cycle(1'b1, 1'b1, 3'b111, 3'b111, 2'b11);

    // Release: PIX_DIV=1 counts 1,2,3 on consecutive clks.
    for (int k = 1; k <= 3; k++) begin
      drive_cycle(1'b0, 1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)));
      check_int("hc after release", int'(a_hc), k);
    end

    // One full default line measured from a fresh start.
    async_reset("line start");
    clear_counts();
    cnt_en = 1'b1;
    run_random(800, 1'b1);
    cnt_en = 1'b0;
    check_int("line de ticks", a_de_n, 640);
    check_int("line hs low ticks", a_hs_low, 96);
    check_int("line_start per line", a_ls, 1);
    check_int("dut_b ticks at div 2", b_ticks, 400);

    // Reset asserted mid-line, then one full small-mode frame with constant red.
    run_random(137, 1'b1);
    async_reset("mid line");
    clear_counts();
    cnt_en = 1'b1;
    for (int i = 0; i < 2 * B_DIV * 0 + 374; i++) begin
      drive_cycle(1'b0, 1'b1, 3'b101, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    end
    cnt_en = 1'b0;
    check_int("frame ticks", b_ticks, 187);
    check_int("frame de ticks", b_de_n, 60);
    check_int("frame_start per frame", b_fs, 1);
    check_int("frame vs ticks", b_vs_hi, 34);
    check_int("colour leak", b_leak, 0);
    check_int("frame_cnt after frame", int'(b_frame_cnt), 1);

    // Enable dropped at hc=300 for 5 clks, then restart.
    async_reset("en drop");
    run_random(300, 1'b1);
    check_int("hc before drop", int'(a_hc), 300);
    drive_cycle(1'b0, 1'b0, 3'b111, 3'b111, 2'b11);
    check_int("hc idle after drop", int'(a_hc), 0);
    check_int("de idle after drop", int'(a_de), 0);
    run_random(4, 1'b0);
    run_random(50, 1'b1);

    // Random bursts with enable drops.
    for (int burst = 0; burst < 5; burst++) begin
      run_random($urandom_range(50, 600), 1'b1);
      run_random($urandom_range(1, 5), 1'b0);
    end
    run_random(40, 1'b1);

    check_int("queue drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
